// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: default widths, FSM states
// and the iteration-counter sizing helper.
package div_pkg;

    localparam int DIVIDEND_W_DEF = 8;
    localparam int DIVISOR_W_DEF  = 4;
    localparam int ITER_COUNT     = DIVIDEND_W_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One extra bit so the count can reach the iteration total without aliasing.
    function automatic int cnt_width(input int iters);
        return $clog2(iters) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, then
// subtract the divisor when it fits.
module div_step
    import div_pkg::*;
#(
    parameter int DIVISOR_W = DIVISOR_W_DEF
) (
    input  logic [DIVISOR_W:0]   part_rem,
    input  logic                 next_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   new_rem,
    output logic                 quo_bit
);

    logic [DIVISOR_W+1:0] shifted_s;

    // Shift, compare and conditionally subtract.
    always_comb begin
        shifted_s = {part_rem, next_bit};
        if (shifted_s >= {2'b00, divisor}) begin
            new_rem = (DIVISOR_W+1)'(shifted_s - {2'b00, divisor});
            quo_bit = 1'b1;
        end else begin
            new_rem = (DIVISOR_W+1)'(shifted_s);
            quo_bit = 1'b0;
        end
    end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, with a
// single-cycle divide-by-zero shortcut and back-to-back start support.
module restoring_divider
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int               CNT_W     = cnt_width(DIVIDEND_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_W - 1);

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    accept_s;
    logic                    zero_div_s;
    logic                    last_iter_s;
    logic                    busy_nxt_s;
    logic                    done_nxt_s;
    logic [DIVIDEND_W-1:0]   work_r;
    logic [DIVISOR_W-1:0]    divisor_r;
    logic [DIVISOR_W:0]      rem_r;
    logic [DIVISOR_W:0]      rem_nxt_s;
    logic                    quo_bit_s;
    logic [CNT_W-1:0]        cnt_r;
    logic                    busy_r;
    logic                    done_r;
    logic [DIVIDEND_W-1:0]   quotient_r;
    logic [DIVISOR_W-1:0]    remainder_r;
    logic                    dbz_r;

    assign accept_s    = start && ((state_r == IDLE) || (state_r == DONE));
    assign zero_div_s  = (divisor == {DIVISOR_W{1'b0}});
    assign last_iter_s = (cnt_r == LAST_ITER);

    div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
        .part_rem (rem_r),
        .next_bit (work_r[DIVIDEND_W-1]),
        .divisor  (divisor_r),
        .new_rem  (rem_nxt_s),
        .quo_bit  (quo_bit_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; IDLE and DONE accept a new request identically.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_nxt_s = zero_div_s ? DONE : RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_iter_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Status decode from the upcoming state so busy/done can be registered.
    always_comb begin
        busy_nxt_s = (state_nxt_s == RUN);
        done_nxt_s = (state_nxt_s == DONE);
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    // Datapath: operand capture, iteration, and result latching at completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= {CNT_W{1'b0}};
            work_r      <= {DIVIDEND_W{1'b0}};
            divisor_r   <= {DIVISOR_W{1'b0}};
            rem_r       <= {(DIVISOR_W+1){1'b0}};
            quotient_r  <= {DIVIDEND_W{1'b0}};
            remainder_r <= {DIVISOR_W{1'b0}};
            dbz_r       <= 1'b0;
        end else if (accept_s) begin
            cnt_r <= {CNT_W{1'b0}};
            rem_r <= {(DIVISOR_W+1){1'b0}};
            if (zero_div_s) begin
                quotient_r  <= {DIVIDEND_W{1'b1}};
                remainder_r <= dividend[DIVISOR_W-1:0];
                dbz_r       <= 1'b1;
            end else begin
                work_r    <= dividend;
                divisor_r <= divisor;
                dbz_r     <= 1'b0;
            end
        end else if (state_r == RUN) begin
            // Quotient bits shift into the vacated low end of the dividend register.
            work_r <= {work_r[DIVIDEND_W-2:0], quo_bit_s};
            rem_r  <= rem_nxt_s;
            cnt_r  <= cnt_r + CNT_W'(1);
            if (last_iter_s) begin
                quotient_r  <= {work_r[DIVIDEND_W-2:0], quo_bit_s};
                remainder_r <= rem_nxt_s[DIVISOR_W-1:0];
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed scenarios plus random
// and exhaustive operands checked against an arithmetic reference model.
module tb_restoring_divider;

    localparam int DW = 8;
    localparam int VW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    restoring_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division; divide-by-zero saturates.
    function automatic void model(input int a, input int b,
                                  output int q, output int r, output int z, output int lat);
        if (b == 0) begin
            q = (1 << DW) - 1;
            r = a % (1 << VW);
            z = 1;
            lat = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
            lat = DW + 1;
        end
    endfunction

    // Present one request, then count cycles until done (bounded).
    task automatic run_op(input int a, input int b, output int lat);
        dividend = DW'(a);
        divisor  = VW'(b);
        start    = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        tick();
        n_checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0)
            $display("FAIL reset_state: busy=%b done=%b q=%0d r=%0d dbz=%b, required all 0",
                     busy, done, quotient, remainder, div_by_zero);
        else n_pass++;
        rst = 1'b0; start = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_start_ignored: busy=%b done=%b, required 0 0", busy, done);
        else n_pass++;
    endtask

    task automatic test_basic();
        int lat;
        dividend = 8'd200; divisor = 4'd7; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL basic_busy: busy=%b, required 1", busy);
        else n_pass++;
        lat = 1;
        while (done !== 1'b1 && lat < 30) begin tick(); lat++; end
        n_checks++;
        if (lat != 9) $display("FAIL basic_latency: got %0d, required 9", lat);
        else n_pass++;
        n_checks++;
        if (quotient !== 8'd28 || remainder !== 4'd4 || div_by_zero !== 1'b0 || busy !== 1'b0)
            $display("FAIL basic_result: q=%0d r=%0d dbz=%b busy=%b, required 28 4 0 0",
                     quotient, remainder, div_by_zero, busy);
        else n_pass++;
        tick(); tick();
        n_checks++;
        if (done !== 1'b0 || quotient !== 8'd28 || remainder !== 4'd4)
            $display("FAIL basic_hold: done=%b q=%0d r=%0d, required 0 28 4", done, quotient, remainder);
        else n_pass++;
    endtask

    task automatic test_extremes();
        int ta[3] = '{255, 5, 255};
        int tb[3] = '{1, 9, 15};
        int tq[3] = '{255, 0, 17};
        int tr[3] = '{0, 5, 0};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], lat);
            n_checks++;
            if (quotient !== DW'(tq[i]) || remainder !== VW'(tr[i]) || lat != 9)
                $display("FAIL extreme_%0d: q=%0d r=%0d lat=%0d, required %0d %0d 9",
                         i, quotient, remainder, lat, tq[i], tr[i]);
            else n_pass++;
        end
    endtask

    task automatic test_div_by_zero();
        int lat;
        run_op(166, 0, lat);
        n_checks++;
        if (lat != 1 || quotient !== 8'hFF || remainder !== 4'h6 || div_by_zero !== 1'b1 || busy !== 1'b0)
            $display("FAIL dbz_result: lat=%0d q=%0h r=%0h dbz=%b busy=%b, required 1 ff 6 1 0",
                     lat, quotient, remainder, div_by_zero, busy);
        else n_pass++;
        run_op(10, 3, lat);
        n_checks++;
        if (quotient !== 8'd3 || remainder !== 4'd1 || div_by_zero !== 1'b0)
            $display("FAIL dbz_clear: q=%0d r=%0d dbz=%b, required 3 1 0", quotient, remainder, div_by_zero);
        else n_pass++;
    endtask

    task automatic test_ignore_busy();
        int lat;
        int extra;
        dividend = 8'd100; divisor = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (lat < 4) begin tick(); lat++; end
        dividend = 8'd9; divisor = 4'd9; start = 1'b1;
        tick();
        lat++;
        start = 1'b0;
        while (done !== 1'b1 && lat < 30) begin tick(); lat++; end
        n_checks++;
        if (lat != 9 || quotient !== 8'd33 || remainder !== 4'd1)
            $display("FAIL ignore_busy_result: lat=%0d q=%0d r=%0d, required 9 33 1", lat, quotient, remainder);
        else n_pass++;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) extra++;
        end
        n_checks++;
        if (extra != 0) $display("FAIL ignore_busy_single_done: extra dones=%0d, required 0", extra);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int seen;
        dividend = 8'd200; divisor = 4'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0)
            $display("FAIL midrun_reset: busy=%b done=%b q=%0d r=%0d dbz=%b, required all 0",
                     busy, done, quotient, remainder, div_by_zero);
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) $display("FAIL midrun_discard: active cycles=%0d, required 0", seen);
        else n_pass++;
        run_op(13, 4, lat);
        n_checks++;
        if (quotient !== 8'd3 || remainder !== 4'd1 || lat != 9)
            $display("FAIL midrun_after: q=%0d r=%0d lat=%0d, required 3 1 9", quotient, remainder, lat);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int ta[6];
        int tb[6];
        int eq, er, ez, el, lat;
        for (int i = 0; i < 6; i++) begin
            ta[i] = int'($urandom_range(0, 255));
            tb[i] = int'($urandom_range(1, 15));
        end
        tb[2] = 0;
        dividend = DW'(ta[0]); divisor = VW'(tb[0]); start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            lat = 1;
            if (i < 5) begin
                dividend = DW'(ta[i+1]);
                divisor  = VW'(tb[i+1]);
            end else begin
                start = 1'b0;
            end
            while (done !== 1'b1 && lat < 30) begin tick(); lat++; end
            model(ta[i], tb[i], eq, er, ez, el);
            n_checks++;
            if (quotient !== DW'(eq) || remainder !== VW'(er) || div_by_zero !== ez[0] || lat != el)
                $display("FAIL b2b_%0d: %0d/%0d q=%0d r=%0d dbz=%b lat=%0d, required %0d %0d %0d %0d",
                         i, ta[i], tb[i], quotient, remainder, div_by_zero, lat, eq, er, ez, el);
            else n_pass++;
        end
        start = 1'b0;
    endtask

    task automatic test_random();
        int a, b, eq, er, ez, el, lat, gap;
        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 15));
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) tick();
            run_op(a, b, lat);
            model(a, b, eq, er, ez, el);
            n_checks++;
            if (quotient !== DW'(eq) || remainder !== VW'(er) || div_by_zero !== ez[0] || lat != el)
                $display("FAIL random_%0d: %0d/%0d q=%0d r=%0d dbz=%b lat=%0d, required %0d %0d %0d %0d",
                         i, a, b, quotient, remainder, div_by_zero, lat, eq, er, ez, el);
            else n_pass++;
        end
    endtask

    task automatic test_sweep();
        int eq, er, ez, el, lat;
        bit ok;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(a, b, lat);
                model(a, b, eq, er, ez, el);
                if (b != 0)
                    ok = (int'(quotient) * b + int'(remainder) == a) && (int'(remainder) < b)
                         && (div_by_zero === 1'b0) && (lat == el);
                else
                    ok = (quotient === DW'(eq)) && (remainder === VW'(er))
                         && (div_by_zero === 1'b1) && (lat == el);
                n_checks++;
                if (!ok)
                    $display("FAIL sweep: %0d/%0d q=%0d r=%0d dbz=%b lat=%0d, required %0d %0d %0d %0d",
                             a, b, quotient, remainder, div_by_zero, lat, eq, er, ez, el);
                else n_pass++;
            end
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 4'd0;
        tick();
        test_reset();
        test_basic();
        test_extremes();
        test_div_by_zero();
        test_ignore_busy();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
